// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam int unsigned WIDX_W   = 13;
    localparam int unsigned BIDX_W   = 2;
    localparam int unsigned TOUT_W   = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_L,
        ST_CNT_H,
        ST_DATA,
        ST_CSUM,
        ST_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } rom_wr_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// ROM write port and loader status bundle.
interface uart_prog_loader_if;
    logic        w_en_o;
    logic [31:0] w_addr_o;
    logic [31:0] w_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport master (output w_en_o, w_addr_o, w_data_o, busy_o, done_o, err_o);
    modport slave  (input  w_en_o, w_addr_o, w_data_o, busy_o, done_o, err_o);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int unsigned CNT_W = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYC - 1);

    logic             rx_s1, rx_s2, rx_s3;
    rx_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_q, bit_n;
    logic [7:0]       shift_q, shift_n;
    logic             vld_n, ferr_n;

    assign byte_data = shift_q;

    // Synchroniser plus one extra stage for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            byte_vld  <= vld_n;
            frame_err <= ferr_n;
        end
    end

    // Bit timer and sampler.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        vld_n   = 1'b0;
        ferr_n  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    state_n = RX_START;
                    cnt_n   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s2, shift_q[7:1]};
                    if (bit_q == 3'd7) state_n = RX_STOP;
                    else               bit_n   = bit_q + 3'd1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_s2) vld_n  = 1'b1;
                    else       ferr_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses A5/count/data/checksum frames into ROM word writes.
// Optional idle timeout while busy is enabled by defining LOADER_TIMEOUT_EN.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORD_MAX  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx_i,
    uart_prog_loader_if.master    rom
);
    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;

    logic        rx_vld, rx_ferr;
    logic [7:0]  rx_data;

    uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx_i),
        .byte_vld  (rx_vld),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    ld_state_t         state_q, state_n;
    logic [7:0]        cnt_lo_q, cnt_lo_n;
    logic [WIDX_W-1:0] word_cnt_q, word_cnt_n;
    logic [WIDX_W-1:0] word_idx_q, word_idx_n;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_n;
    logic [7:0]        csum_q, csum_n;
    logic [31:0]       buf_q, buf_n;
    logic [31:0]       word_c;
    logic [15:0]       n_c;
    rom_wr_t           wr_q, wr_n;
    logic              w_en_q, w_en_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 16 * 10 * BIT_CYC;
    logic [TOUT_W-1:0] tout_q, tout_n;

    // Idle counter, restarted by every received byte and held clear while not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tout_q <= '0;
        else        tout_q <= tout_n;
    end
`endif

    assign rom.w_en_o   = w_en_q;
    assign rom.w_addr_o = wr_q.addr;
    assign rom.w_data_o = wr_q.data;
    assign rom.busy_o   = busy_q;
    assign rom.done_o   = done_q;
    assign rom.err_o    = err_q;

    // Loader state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_lo_q   <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            buf_q      <= '0;
            wr_q       <= '0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_lo_q   <= cnt_lo_n;
            word_cnt_q <= word_cnt_n;
            word_idx_q <= word_idx_n;
            byte_idx_q <= byte_idx_n;
            csum_q     <= csum_n;
            buf_q      <= buf_n;
            wr_q       <= wr_n;
            w_en_q     <= w_en_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    // Frame parser, word assembly and checksum.
    always_comb begin
        state_n    = state_q;
        cnt_lo_n   = cnt_lo_q;
        word_cnt_n = word_cnt_q;
        word_idx_n = word_idx_q;
        byte_idx_n = byte_idx_q;
        csum_n     = csum_q;
        buf_n      = buf_q;
        wr_n       = wr_q;
        w_en_n     = 1'b0;
        busy_n     = busy_q;
        done_n     = 1'b0;
        err_n      = err_q;
        n_c        = {rx_data, cnt_lo_q};
        word_c     = buf_q;
        word_c[{byte_idx_q, 3'b000} +: 8] = rx_data;
`ifdef LOADER_TIMEOUT_EN
        tout_n     = (rx_vld || !busy_q) ? '0 : tout_q + TOUT_W'(1);
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_vld && rx_data == HDR_BYTE) begin
                    state_n = ST_CNT_L;
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
                end
            end
            ST_CNT_L: begin
                if (rx_vld) begin
                    cnt_lo_n = rx_data;
                    state_n  = ST_CNT_H;
                end
            end
            ST_CNT_H: begin
                if (rx_vld) begin
                    if (n_c == 16'd0 || 32'(n_c) > WORD_MAX) begin
                        state_n = ST_ERR;
                    end else begin
                        state_n    = ST_DATA;
                        word_cnt_n = WIDX_W'(n_c);
                        word_idx_n = '0;
                        byte_idx_n = '0;
                        csum_n     = '0;
                    end
                end
            end
            ST_DATA: begin
                if (rx_vld) begin
                    buf_n      = word_c;
                    csum_n     = csum_q + rx_data;
                    byte_idx_n = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        w_en_n    = 1'b1;
                        wr_n.addr = BASE_ADDR + {17'b0, word_idx_q, 2'b00};
                        wr_n.data = word_c;
                        if (word_idx_q == word_cnt_q - WIDX_W'(1)) state_n    = ST_CSUM;
                        else                                       word_idx_n = word_idx_q + WIDX_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (rx_vld) begin
                    if (rx_data == csum_q) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (rx_ferr && state_q != ST_IDLE && state_q != ST_ERR) state_n = ST_ERR;
`ifdef LOADER_TIMEOUT_EN
        if (busy_q && tout_q == TOUT_W'(TIMEOUT_CYC - 1)) state_n = ST_ERR;
`endif
        if (state_n == ST_ERR && state_q != ST_ERR) begin
            err_n  = 1'b1;
            busy_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed frames, queued expected ROM writes.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int unsigned BIT_CYC     = 16;
    localparam int unsigned TIMEOUT_CYC = 16 * 10 * BIT_CYC;

    typedef logic [7:0] bq_t[$];

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic uart_rx_i = 1'b1;

    uart_prog_loader_if bus ();

    uart_prog_loader #(
        .CLK_FREQ  (1600),
        .BAUD      (100),
        .BASE_ADDR (32'h0000_0000),
        .WORD_MAX  (4096)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx_i),
        .rom       (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse is matched against the head of the expected queue.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (bus.done_o) done_cnt++;
        if (bus.w_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.w_addr_o, bus.w_data_o);
            end else begin
                e = exp_q.pop_front();
                check("rom_write", {bus.w_addr_o, bus.w_data_o}, e);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (BIT_CYC) @(posedge clk);
        end
        uart_rx_i = stop;
        repeat (BIT_CYC) @(posedge clk);
        uart_rx_i = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_bytes(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic check_status(input string name, input logic busy, input logic err);
        check({name, "_busy"}, 64'(bus.busy_o), 64'(busy));
        check({name, "_err"},  64'(bus.err_o),  64'(err));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"},  64'({bus.w_en_o, bus.busy_o, bus.done_o, bus.err_o}), 64'd0);
        check({name, "_addr"}, 64'(bus.w_addr_o), 64'd0);
        check({name, "_data"}, 64'(bus.w_data_o), 64'd0);
    endtask

    initial begin
        int d0;
        int elapsed;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        settle();

        // Two-word frame with a start-bit glitch between header and count
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0000_00B7});
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1);
        uart_rx_i = 1'b0;
        repeat (3) @(posedge clk);
        uart_rx_i = 1'b1;
        repeat (30) @(posedge clk);
        settle();
        check_status("t1_hdr", 1'b1, 1'b0);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'hB7, 8'h00, 8'h00, 8'h00, 8'hCA});
        settle();
        check("t1_done", 64'(done_cnt - d0), 64'd1);
        check_status("t1_end", 1'b0, 1'b0);
        check("t1_pending", 64'(exp_q.size()), 64'd0);
        check("t1_addr_hold", 64'(bus.w_addr_o), 64'h4);
        check("t1_data_hold", 64'(bus.w_data_o), 64'hB7);

        // Same frame, bad checksum
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0000_00B7});
        d0 = done_cnt;
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'hB7, 8'h00, 8'h00, 8'h00, 8'hCB});
        settle();
        check("t2_done", 64'(done_cnt - d0), 64'd0);
        check_status("t2_end", 1'b0, 1'b1);
        check("t2_pending", 64'(exp_q.size()), 64'd0);

        // Zero count: header clears err, count sets it again
        send_byte(8'hA5, 1'b1);
        settle();
        check_status("t3_hdr", 1'b1, 1'b0);
        send_bytes('{8'h00, 8'h00});
        settle();
        check_status("t3_end", 1'b0, 1'b1);

        // Count 4097 exceeds WORD_MAX
        send_bytes('{8'hA5, 8'h01, 8'h10});
        settle();
        check_status("t4_end", 1'b0, 1'b1);

        // Leading junk ignored in IDLE, then one word; checksum EF+BE+AD+DE = 0x38
        send_bytes('{8'h3C, 8'h5A});
        settle();
        check_status("t5_junk", 1'b0, 1'b1);
        exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        d0 = done_cnt;
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38});
        settle();
        check("t5_done", 64'(done_cnt - d0), 64'd1);
        check_status("t5_end", 1'b0, 1'b0);

        // Reset mid-word, then a fresh frame
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
        @(negedge clk);
        check_status("t6_pre", 1'b1, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("t6_rst");
        end
        rst_n = 1'b1;
        settle();
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        d0 = done_cnt;
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA});
        settle();
        check("t6_done", 64'(done_cnt - d0), 64'd1);
        check_status("t6_end", 1'b0, 1'b0);

        // Header value inside data is plain data; checksum 4*A5 = 0x94
        exp_q.push_back({32'h0000_0000, 32'hA5A5_A5A5});
        d0 = done_cnt;
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94});
        settle();
        check("t7_done", 64'(done_cnt - d0), 64'd1);
        check_status("t7_end", 1'b0, 1'b0);

        // Stop bit low on the second data byte
        d0 = done_cnt;
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h01});
        send_byte(8'h02, 1'b0);
        settle();
        check_status("t8_end", 1'b0, 1'b1);
        send_bytes('{8'h03, 8'h04, 8'h0A});
        settle();
        check("t8_done", 64'(done_cnt - d0), 64'd0);

`ifdef LOADER_TIMEOUT_EN
        // Line goes quiet mid-frame
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h11});
        elapsed = 0;
        while (!bus.err_o && elapsed < int'(TIMEOUT_CYC) + 200) begin
            @(negedge clk);
            elapsed++;
        end
        check("t9_timeout_fired", 64'(bus.err_o), 64'd1);
        check("t9_timeout_window",
              64'(elapsed >= int'(TIMEOUT_CYC) - 30 && elapsed <= int'(TIMEOUT_CYC) + 5), 64'd1);
        settle();
        check_status("t9_end", 1'b0, 1'b1);
`else
        elapsed = 0;
`endif

        check("final_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
